// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply/divide (MULTU/MULT/DIVU/DIV) producing HI/LO in 34 cycles.
module muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        dz_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        s1_q, s1_d, s2_q, s2_d, dz_q, dz_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] mag1, mag2, quo, rmd;
    logic [32:0] sum;
    logic [33:0] sh, diff;
    logic [63:0] prod;
    always_comb begin
        mag1 = (op_i[0] && src1_i[31]) ? -src1_i : src1_i;
        mag2 = (op_i[0] && src2_i[31]) ? -src2_i : src2_i;
        sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        sh   = {rem_q, acc_q[31]};
        diff = sh - {2'b00, b_q};
        prod = (op_q[0] && (s1_q ^ s2_q)) ? -acc_q : acc_q;
        quo  = (op_q[0] && (s1_q ^ s2_q)) ? -acc_q[31:0] : acc_q[31:0];
        rmd  = (op_q[0] && s1_q) ? -rem_q[31:0] : rem_q[31:0];
        state_d = state_q;
        op_d    = op_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (start_i) begin
                op_d  = op_i;
                s1_d  = src1_i[31];
                s2_d  = src2_i[31];
                cnt_d = 6'd0;
                b_d   = op_i[1] ? mag2 : mag1;
                acc_d = {32'd0, op_i[1] ? mag1 : mag2};
                rem_d = 33'd0;
                dz_d  = op_i[1] && (src2_i == 32'd0);
                if (op_i[1] && (src2_i == 32'd0)) begin
                    hi_d    = src1_i;
                    lo_d    = 32'hFFFF_FFFF;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (op_q[1]) begin
                    rem_d = diff[33] ? sh[32:0] : diff[32:0];
                    acc_d = {32'd0, acc_q[30:0], ~diff[33]};
                end else begin
                    acc_d = {sum, acc_q[31:1]};
                end
                state_d = (cnt_q == 6'd31) ? FIX : CALC;
            end
            FIX: begin
                hi_d    = op_q[1] ? rmd : prod[63:32];
                lo_d    = op_q[1] ? quo : prod[31:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= 6'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            rem_q   <= 33'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign busy_o = (state_q == CALC) || (state_q == FIX);
    assign done_o = (state_q == DONE);
    assign dz_o   = (state_q == DONE) && dz_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule
